// File: rtl/insert_mul_arb_pkg.sv
// Shared defaults and helpers for the insert-path multiplier arbiter.
package insert_mul_arb_pkg;

   localparam int N_REQ_DEF = 4;
   localparam int A_W_DEF   = 14;
   localparam int B_W_DEF   = 8;
   localparam int P_W_DEF   = 20;
   localparam int CNT_W_DEF = 16;

   // Tag width needed to name n requesters (at least one bit).
   function automatic int id_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Round-robin successor of the granted index.
   function automatic int unsigned rr_next(input int unsigned g, input int unsigned n);
      return (g + 1 >= n) ? 0 : g + 1;
   endfunction

endpackage

// File: rtl/insert_mul_arb_core.sv
// Unsigned multiply truncated to P_W bits; combinational, registered by the caller's S2.
module insert_mul_arb_core
   import insert_mul_arb_pkg::*;
#(
   parameter int A_W = A_W_DEF,
   parameter int B_W = B_W_DEF,
   parameter int P_W = P_W_DEF
) (
   input  logic [A_W-1:0] a,
   input  logic [B_W-1:0] b,
   output logic [P_W-1:0] p
);

   logic [A_W+B_W-1:0] full;

   assign full = {{B_W{1'b0}}, a} * {{A_W{1'b0}}, b};
   assign p    = full[P_W-1:0];

endmodule

// File: rtl/insert_mul_arbiter.sv
// Round-robin arbiter feeding one shared two-stage multiplier pipeline.
// Define INSERT_MUL_ARB_STATS_EN to build the per-requester grant counters.
module insert_mul_arbiter
   import insert_mul_arb_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int A_W   = A_W_DEF,
   parameter int B_W   = B_W_DEF,
   parameter int P_W   = P_W_DEF,
   parameter int ID_W  = 2,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic               ap_clk,
   input  logic               ap_rst_n,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [N_REQ*A_W-1:0] req_a,
   input  logic [N_REQ*B_W-1:0] req_b,
   output logic [N_REQ-1:0]   req_ready,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [P_W-1:0]     out_p,
   output logic [ID_W-1:0]    out_id,
   output logic               busy,
   output logic [N_REQ*CNT_W-1:0] grant_cnt
);

   logic [2:1]      vld_pipe;
   logic [A_W-1:0]  s1_a;
   logic [B_W-1:0]  s1_b;
   logic [ID_W-1:0] s1_id;
   logic [ID_W-1:0] rr_ptr;
   logic [ID_W-1:0] grant;
   logic            gnt_any;
   logic            adv1, adv2, accept;
   logic [A_W-1:0]  sel_a;
   logic [B_W-1:0]  sel_b;
   logic [P_W-1:0]  prod;

   assign adv2      = !vld_pipe[2] | out_ready;
   assign adv1      = !vld_pipe[1] | adv2;
   assign accept    = gnt_any & adv1;
   assign out_valid = vld_pipe[2];
   assign busy      = |vld_pipe;

   // First valid requester at or after rr_ptr, wrapping.
   always_comb begin
      int j;
      int gi;
      j         = 0;
      gi        = 0;
      gnt_any   = 1'b0;
      grant     = '0;
      req_ready = '0;
      for (int k = 0; k < N_REQ; k++) begin
         j = (int'(rr_ptr) + k) % N_REQ;
         if (!gnt_any && req_valid[j]) begin
            gnt_any = 1'b1;
            grant   = ID_W'(j);
         end
      end
      gi    = int'(grant);
      sel_a = req_a[gi*A_W +: A_W];
      sel_b = req_b[gi*B_W +: B_W];
      if (gnt_any) req_ready[gi] = adv1;
   end

   insert_mul_arb_core #(.A_W(A_W), .B_W(B_W), .P_W(P_W)) u_core (
      .a (s1_a),
      .b (s1_b),
      .p (prod)
   );

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         vld_pipe <= '0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_id    <= '0;
         out_p    <= '0;
         out_id   <= '0;
         rr_ptr   <= '0;
      end else begin
         if (adv1) begin
            vld_pipe[1] <= accept;
            if (accept) begin
               s1_a  <= sel_a;
               s1_b  <= sel_b;
               s1_id <= grant;
            end
         end
         // S2 payload only reloads on a real move so a stalled result stays put.
         if (adv2) begin
            vld_pipe[2] <= vld_pipe[1];
            if (vld_pipe[1]) begin
               out_p  <= prod;
               out_id <= s1_id;
            end
         end
         if (accept) rr_ptr <= ID_W'(rr_next(int'(grant), N_REQ));
      end
   end

`ifdef INSERT_MUL_ARB_STATS_EN
   for (genvar i = 0; i < N_REQ; i++) begin : g_cnt
      logic [CNT_W-1:0] cnt;
      always_ff @(posedge ap_clk) begin
         if (!ap_rst_n)
            cnt <= '0;
         else if (accept && grant == ID_W'(i) && cnt != {CNT_W{1'b1}})
            cnt <= cnt + 1'b1;
      end
      assign grant_cnt[i*CNT_W +: CNT_W] = cnt;
   end
`else
   assign grant_cnt = '0;
`endif

endmodule
